data_mem_resp: RTL

DATA_MEM_RESP -- requirements
Module: data_mem_resp

---
 rtl/data_mem_resp.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/data_mem_resp.sv
// Byte-addressed RV32I load/store responder with fixed wait states and a valid/ready response.
// Define DATA_MEM_RESP_MISALIGN_TRAP_EN to reject misaligned H/HU/W accesses instead of splitting.
module data_mem_resp #(
    parameter int unsigned ADDRESS_WIDTH = 8,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned WAIT_CYCLES   = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_we,
    input  logic [ADDRESS_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0]    req_wdata,
    input  logic [2:0]               req_funct3,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [DATA_WIDTH-1:0]    resp_rdata,
    output logic                     resp_err
);

    localparam int unsigned LP_DEPTH    = 1 << ADDRESS_WIDTH;
    localparam bit          LP_NO_WAIT  = (WAIT_CYCLES == 0);
    localparam logic [3:0]  LP_CNT_INIT = LP_NO_WAIT ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_e;

    state_e r_state;
    state_e w_state_next;

    logic                     r_rdy_en;
    logic [3:0]               r_cnt;
    logic                     r_we;
    logic [ADDRESS_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0]    r_wdata;
    logic [2:0]               r_funct3;
    logic [DATA_WIDTH-1:0]    r_rdata;
    logic                     r_err;

    logic [7:0] r_mem [LP_DEPTH];

    logic                     w_accept;
    logic                     w_enter_resp;
    logic                     w_commit;
    logic                     w_op_we;
    logic [ADDRESS_WIDTH-1:0] w_op_addr;
    logic [DATA_WIDTH-1:0]    w_op_wdata;
    logic [2:0]               w_op_funct3;
    logic [ADDRESS_WIDTH-1:0] w_addr_b [4];
    logic [DATA_WIDTH-1:0]    w_rword;
    logic [DATA_WIDTH-1:0]    w_rdata_ext;
    logic [3:0]               w_be;
    logic                     w_f3_ok;
    logic                     w_misalign;
    logic                     w_err;

    assign w_accept = req_valid & req_ready;

    // With no wait states the operation completes on the acceptance edge, so it
    // must be taken from the live request inputs rather than the capture registers.
    assign w_enter_resp = ((r_state == StIdle) & w_accept & LP_NO_WAIT) |
                          ((r_state == StWait) & (r_cnt == 4'd0));

    assign w_op_we     = (r_state == StIdle) ? req_we     : r_we;
    assign w_op_addr   = (r_state == StIdle) ? req_addr   : r_addr;
    assign w_op_wdata  = (r_state == StIdle) ? req_wdata  : r_wdata;
    assign w_op_funct3 = (r_state == StIdle) ? req_funct3 : r_funct3;

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle: begin
                if (w_accept) begin
                    w_state_next = LP_NO_WAIT ? StResp : StWait;
                end
            end
            StWait: begin
                if (r_cnt == 4'd0) begin
                    w_state_next = StResp;
                end
            end
            StResp: begin
                if (resp_ready) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    // FSM outputs; r_rdy_en holds req_ready low until the first edge after reset
    always_comb begin
        req_ready  = (r_state == StIdle) & r_rdy_en;
        resp_valid = (r_state == StResp);
    end

    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_addr_b[i] = w_op_addr + ADDRESS_WIDTH'(i);
        end
    end

    assign w_rword = {r_mem[w_addr_b[3]], r_mem[w_addr_b[2]],
                      r_mem[w_addr_b[1]], r_mem[w_addr_b[0]]};

    always_comb begin
        w_be        = 4'b0000;
        w_f3_ok     = 1'b1;
        w_rdata_ext = '0;
        case (w_op_funct3)
            3'b000: begin
                w_be        = 4'b0001;
                w_rdata_ext = {{24{w_rword[7]}}, w_rword[7:0]};
            end
            3'b100: begin
                w_be        = 4'b0001;
                w_rdata_ext = {24'd0, w_rword[7:0]};
            end
            3'b001: begin
                w_be        = 4'b0011;
                w_rdata_ext = {{16{w_rword[15]}}, w_rword[15:0]};
            end
            3'b101: begin
                w_be        = 4'b0011;
                w_rdata_ext = {16'd0, w_rword[15:0]};
            end
            3'b010: begin
                w_be        = 4'b1111;
                w_rdata_ext = w_rword;
            end
            default: w_f3_ok = 1'b0;
        endcase
    end

`ifdef DATA_MEM_RESP_MISALIGN_TRAP_EN
    assign w_misalign = ((w_op_funct3[1:0] == 2'b01) & w_op_addr[0]) |
                        ((w_op_funct3 == 3'b010) & (w_op_addr[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    assign w_err    = ~w_f3_ok | w_misalign;
    assign w_commit = w_enter_resp & w_op_we & ~w_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rdy_en <= 1'b0;
            r_cnt    <= 4'd0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_funct3 <= 3'b000;
            r_rdata  <= '0;
            r_err    <= 1'b0;
        end else begin
            r_rdy_en <= 1'b1;
            if ((r_state == StIdle) && w_accept) begin
                r_we     <= req_we;
                r_addr   <= req_addr;
                r_wdata  <= req_wdata;
                r_funct3 <= req_funct3;
                r_cnt    <= LP_CNT_INIT;
            end else if ((r_state == StWait) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_enter_resp) begin
                r_err   <= w_err;
                r_rdata <= (w_err || w_op_we) ? '0 : w_rdata_ext;
            end
        end
    end

    // Array is deliberately left out of reset
    always_ff @(posedge clk) begin
        if (w_commit) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    r_mem[w_addr_b[i]] <= w_op_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule
